// File: rtl/scl_poly4_filter.sv
// ---------------------------------------------------------------------------
// scl_poly4_filter
//
// Four-tap polyphase FIR applied independently to CH packed channels of a
// pixel stream in the horizontal scaler path (clk_scl domain). Each output is
//   y[k] = c0*x[k-1] + c1*x[k] + c2*x[k+1] + c3*x[k+2]
// with edge replication at line boundaries, optional round-half-up before
// the fractional shift, clamping to [0, 2^DW-1] and a clip flag. A contiguous
// run of scl_i_data_en = 1 is one line. Config and the selected coefficient
// set are captured at the first sample of a line and travel with every
// sample of that line, so neither config changes nor table writes can
// disturb a line already in the pipe. Fixed latency is 7 cycles, en to en.
//
// Ports
//   clk_scl          clock
//   rst_n_scl        asynchronous active-low reset
//   scl_cfg_mode     1 = filter, 0 = bypass (x[k] passed through)
//   scl_cfg_phase    coefficient phase used by the next line
//   scl_cfg_rnd      1 = add 2^(FRAC-1) before the shift, 0 = truncate
//   scl_coef_we      coefficient table write strobe
//   scl_coef_sel     phase written by scl_coef_we
//   scl_coef_wdata   {c3,c2,c1,c0}, c0 in the LSBs, signed CW bits each
//   scl_i_data       input pixel, channel c at [c*DW +: DW]
//   scl_i_data_en    input valid
//   scl_o_data       output pixel (holds while scl_o_data_en = 0)
//   scl_o_data_en    output valid
//   scl_o_sat        some channel of the current output pixel was clipped
// ---------------------------------------------------------------------------
module scl_poly4_filter #(
    parameter  int DW   = 8,
    parameter  int CH   = 3,
    parameter  int CW   = 11,
    parameter  int FRAC = 9,
    parameter  int NPH  = 4,
    localparam int PW   = (NPH > 1) ? $clog2(NPH) : 1
) (
    input  logic             clk_scl,
    input  logic             rst_n_scl,
    input  logic             scl_cfg_mode,
    input  logic [PW-1:0]    scl_cfg_phase,
    input  logic             scl_cfg_rnd,
    input  logic             scl_coef_we,
    input  logic [PW-1:0]    scl_coef_sel,
    input  logic [4*CW-1:0]  scl_coef_wdata,
    input  logic [CH*DW-1:0] scl_i_data,
    input  logic             scl_i_data_en,
    output logic [CH*DW-1:0] scl_o_data,
    output logic             scl_o_data_en,
    output logic             scl_o_sat
);

    localparam int NTAB = 1 << PW;          // table covers every phase code
    localparam int PRW  = DW + 1 + CW;      // product width
    localparam int ACW  = DW + CW + 3;      // accumulator width

    localparam logic signed [ACW-1:0] RND_HALF = ACW'(1 << (FRAC - 1));
    localparam logic signed [ACW-1:0] MAX_PIX  = ACW'((1 << DW) - 1);

    // Per-line configuration; one copy rides along with every sample.
    typedef struct packed {
        logic            mode;
        logic            rnd;
        logic [4*CW-1:0] coef;
    } cfg_t;

    function automatic logic [4*CW-1:0] pack_coef(input int c0, input int c1,
                                                  input int c2, input int c3);
        return {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
    endfunction

    function automatic logic [4*CW-1:0] default_coef(input int p);
        logic [4*CW-1:0] r;
        r = pack_coef(0, 1 << FRAC, 0, 0);
        if (FRAC == 9) begin
            case (p)
                0:       r = pack_coef(-3, 498, 18, -1);
                1:       r = pack_coef(-38, 376, 202, -28);
                2:       r = pack_coef(-28, 202, 376, -38);
                3:       r = pack_coef(-1, 18, 498, -3);
                default: ;
            endcase
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Line qualification
    // ------------------------------------------------------------------
    // After reset, input is ignored until en has been seen low once, so a
    // line cut by reset cannot resurface as a partial line after release.
    logic armed;
    logic in_en;
    logic line_start;

    always_ff @(posedge clk_scl or negedge rst_n_scl) begin
        if (!rst_n_scl) begin
            armed <= 1'b0;
        end else if (!scl_i_data_en) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            armed <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Coefficient table
    // ------------------------------------------------------------------
    logic [4*CW-1:0] coef_tab [NTAB];

    always_ff @(posedge clk_scl or negedge rst_n_scl) begin
        if (!rst_n_scl) begin
            // NOTE: this table is a small register file, not a RAM, so it is
            // reset entry by entry to restore the default phases.
            for (int p = 0; p < NTAB; p++) begin
                coef_tab[p] <= default_coef(p);
            end
        end else if (scl_coef_we) begin
            for (int p = 0; p < NPH; p++) begin
                if (scl_coef_sel == PW'(p)) begin
                    coef_tab[p] <= scl_coef_wdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Config capture and sample window
    // ------------------------------------------------------------------
    // Window slot 0 holds the newest sample. With the centre in slot 2 the
    // taps are x[k-1] = slot 3, x[k] = slot 2, x[k+1] = slot 1, x[k+2] = slot 0.
    cfg_t             w_cfg [3];
    logic [CH*DW-1:0] w_px  [4];
    logic [3:0]       w_v;

    logic [4*CW-1:0]  sel_coef;
    cfg_t             cur_cfg;

    assign in_en      = scl_i_data_en & armed;
    assign line_start = in_en & ~w_v[0];

    always_comb begin
        // NOTE: every variable gets a default at the top of a combinational
        // block so no path leaves it unassigned and no latch is inferred.
        sel_coef = coef_tab[scl_cfg_phase];
        cur_cfg  = w_cfg[0];
        // Write-first: a line starting on the write cycle sees the new set.
        if (scl_coef_we && (scl_coef_sel == scl_cfg_phase)) begin
            sel_coef = scl_coef_wdata;
        end
        // Mid-line samples inherit the config of the previous sample, which
        // is necessarily the same line.
        if (line_start) begin
            cur_cfg.mode = scl_cfg_mode;
            cur_cfg.rnd  = scl_cfg_rnd;
            cur_cfg.coef = sel_coef;
        end
    end

    always_ff @(posedge clk_scl or negedge rst_n_scl) begin
        if (!rst_n_scl) begin
            w_v <= '0;
            for (int i = 0; i < 4; i++) begin
                w_px[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                w_cfg[i] <= '0;
            end
        end else begin
            w_v     <= {w_v[2:0], in_en};
            w_px[0] <= scl_i_data;
            w_cfg[0] <= cur_cfg;
            for (int i = 1; i < 4; i++) begin
                w_px[i] <= w_px[i-1];
            end
            for (int i = 1; i < 3; i++) begin
                w_cfg[i] <= w_cfg[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge replication and products
    // ------------------------------------------------------------------
    // Lines are separated by at least one idle cycle, so two adjacent valid
    // slots always belong to the same line. A tap outside the line falls
    // back to the nearest in-line sample.
    logic [DW-1:0]         tap  [CH][4];
    logic signed [PRW-1:0] prod [CH][4];

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            tap[c][1] = w_px[2][c*DW +: DW];
            tap[c][0] = w_v[3] ? w_px[3][c*DW +: DW] : w_px[2][c*DW +: DW];
            tap[c][2] = w_v[1] ? w_px[1][c*DW +: DW] : w_px[2][c*DW +: DW];
            tap[c][3] = (w_v[1] && w_v[0]) ? w_px[0][c*DW +: DW] : tap[c][2];
        end
    end

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            for (int j = 0; j < 4; j++) begin
                prod[c][j] = PRW'($signed({1'b0, tap[c][j]}))
                           * PRW'($signed(w_cfg[2].coef[j*CW +: CW]));
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline: products -> pair sums -> final sum
    // ------------------------------------------------------------------
    logic signed [PRW-1:0] s1_prod [CH][4];
    logic                  s1_v, s1_mode, s1_rnd;
    logic [CH*DW-1:0]      s1_px;

    logic signed [ACW-1:0] s2_pair [CH][2];
    logic                  s2_v, s2_mode, s2_rnd;
    logic [CH*DW-1:0]      s2_px;

    logic signed [ACW-1:0] s3_sum [CH];
    logic                  s3_v, s3_mode, s3_rnd;
    logic [CH*DW-1:0]      s3_px;

    always_ff @(posedge clk_scl or negedge rst_n_scl) begin
        if (!rst_n_scl) begin
            s1_prod <= '{default: '0};
            s2_pair <= '{default: '0};
            s3_sum  <= '{default: '0};
            {s1_v, s1_mode, s1_rnd, s1_px} <= '0;
            {s2_v, s2_mode, s2_rnd, s2_px} <= '0;
            {s3_v, s3_mode, s3_rnd, s3_px} <= '0;
        end else begin
            s1_prod <= prod;
            s1_v    <= w_v[2];
            s1_mode <= w_cfg[2].mode;
            s1_rnd  <= w_cfg[2].rnd;
            s1_px   <= w_px[2];

            for (int c = 0; c < CH; c++) begin
                s2_pair[c][0] <= ACW'(s1_prod[c][0]) + ACW'(s1_prod[c][1]);
                s2_pair[c][1] <= ACW'(s1_prod[c][2]) + ACW'(s1_prod[c][3]);
            end
            s2_v    <= s1_v;
            s2_mode <= s1_mode;
            s2_rnd  <= s1_rnd;
            s2_px   <= s1_px;

            for (int c = 0; c < CH; c++) begin
                s3_sum[c] <= s2_pair[c][0] + s2_pair[c][1];
            end
            s3_v    <= s2_v;
            s3_mode <= s2_mode;
            s3_rnd  <= s2_rnd;
            s3_px   <= s2_px;
        end
    end

    // ------------------------------------------------------------------
    // Round, shift, clamp and output register
    // ------------------------------------------------------------------
    logic [CH*DW-1:0]      res_px;
    logic                  res_clip;
    logic signed [ACW-1:0] acc;
    logic signed [ACW-1:0] shr;

    always_comb begin
        res_px   = '0;
        res_clip = 1'b0;
        acc      = '0;
        shr      = '0;
        for (int c = 0; c < CH; c++) begin
            if (s3_rnd) begin
                acc = s3_sum[c] + RND_HALF;
            end else begin
                acc = s3_sum[c];
            end
            shr = acc >>> FRAC;
            if (shr[ACW-1]) begin
                res_px[c*DW +: DW] = '0;
                res_clip           = 1'b1;
            end else if (shr > MAX_PIX) begin
                res_px[c*DW +: DW] = '1;
                res_clip           = 1'b1;
            end else begin
                res_px[c*DW +: DW] = shr[DW-1:0];
            end
        end
    end

    always_ff @(posedge clk_scl or negedge rst_n_scl) begin
        if (!rst_n_scl) begin
            scl_o_data    <= '0;
            scl_o_data_en <= 1'b0;
            scl_o_sat     <= 1'b0;
        end else begin
            scl_o_data_en <= s3_v;
            scl_o_sat     <= s3_v & s3_mode & res_clip;
            if (s3_v) begin
                scl_o_data <= s3_mode ? res_px : s3_px;
            end
        end
    end

endmodule

// File: tb/tb_scl_poly4_filter.sv
// ---------------------------------------------------------------------------
// tb_scl_poly4_filter
//
// Directed-vector bench for scl_poly4_filter. Each driven sample pushes its
// hand-computed expected pixel, clip flag and arrival cycle into a queue; a
// monitor on the falling edge pops and compares whenever scl_o_data_en is
// high, and checks the idle-hold behaviour otherwise.
// ---------------------------------------------------------------------------
module tb_scl_poly4_filter;

    localparam int DW  = 8;
    localparam int CH  = 3;
    localparam int CW  = 11;
    localparam int PW  = 2;
    localparam int PXW = CH * DW;
    localparam logic [4*CW-1:0] IDENT = {11'd0, 11'd0, 11'd512, 11'd0};

    logic             clk_scl = 1'b0;
    logic             rst_n_scl;
    logic             scl_cfg_mode;
    logic [PW-1:0]    scl_cfg_phase;
    logic             scl_cfg_rnd;
    logic             scl_coef_we;
    logic [PW-1:0]    scl_coef_sel;
    logic [4*CW-1:0]  scl_coef_wdata;
    logic [PXW-1:0]   scl_i_data;
    logic             scl_i_data_en;
    logic [PXW-1:0]   scl_o_data;
    logic             scl_o_data_en;
    logic             scl_o_sat;

    scl_poly4_filter dut (
        .clk_scl        (clk_scl),
        .rst_n_scl      (rst_n_scl),
        .scl_cfg_mode   (scl_cfg_mode),
        .scl_cfg_phase  (scl_cfg_phase),
        .scl_cfg_rnd    (scl_cfg_rnd),
        .scl_coef_we    (scl_coef_we),
        .scl_coef_sel   (scl_coef_sel),
        .scl_coef_wdata (scl_coef_wdata),
        .scl_i_data     (scl_i_data),
        .scl_i_data_en  (scl_i_data_en),
        .scl_o_data     (scl_o_data),
        .scl_o_data_en  (scl_o_data_en),
        .scl_o_sat      (scl_o_sat)
    );

    always #5 clk_scl = ~clk_scl;

    typedef struct {
        logic [PXW-1:0] data;
        logic           sat;
        int             cyc;
        logic [8*10-1:0] tag;
    } exp_t;

    exp_t           sb [$];
    int             n_checks = 0;
    int             n_fail   = 0;
    int             cyc      = 0;
    logic [PXW-1:0] last_exp = '0;

    logic [PXW-1:0] line_px [8];
    logic [PXW-1:0] exp_px  [8];
    logic           exp_sat [8];

    always @(posedge clk_scl) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [PXW-1:0] px(input logic [7:0] c2, input logic [7:0] c1,
                                          input logic [7:0] c0);
        return {c2, c1, c0};
    endfunction

    function automatic logic [PXW-1:0] px3(input logic [7:0] v);
        return {v, v, v};
    endfunction

    task automatic put(input int i, input logic [PXW-1:0] x, input logic [PXW-1:0] y,
                       input logic s);
        line_px[i] = x;
        exp_px[i]  = y;
        exp_sat[i] = s;
    endtask

    // Drives line_px[0..n-1]; config is applied with the first sample. At
    // sample wr_idx an identity set is written to phase wr_sel, and with
    // chg set the phase input also switches to wr_sel on that sample.
    task automatic drive_line(input logic [8*10-1:0] tag, input int n, input logic mode,
                              input logic [PW-1:0] phase, input logic rnd, input int wr_idx,
                              input logic [PW-1:0] wr_sel, input logic chg, input int idle);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_scl);
            #1;
            scl_i_data    = line_px[i];
            scl_i_data_en = 1'b1;
            if (i == 0) begin
                scl_cfg_mode  = mode;
                scl_cfg_phase = phase;
                scl_cfg_rnd   = rnd;
            end
            scl_coef_we = 1'b0;
            if (i == wr_idx) begin
                scl_coef_we    = 1'b1;
                scl_coef_sel   = wr_sel;
                scl_coef_wdata = IDENT;
                if (chg) scl_cfg_phase = wr_sel;
            end
            e.data = exp_px[i];
            e.sat  = exp_sat[i];
            e.cyc  = cyc + 7;
            e.tag  = tag;
            sb.push_back(e);
        end
        @(posedge clk_scl);
        #1;
        scl_i_data_en = 1'b0;
        scl_i_data    = '0;
        scl_coef_we   = 1'b0;
        repeat (idle - 1) @(posedge clk_scl);
    endtask

    // Monitor: compares every presented output against the queue head.
    always @(negedge clk_scl) begin
        exp_t e;
        if (rst_n_scl) begin
            if (scl_o_data_en) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got data 0x%0h at cycle %0d, expected no output",
                             scl_o_data, cyc);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("data %s", e.tag), 32'(scl_o_data), 32'(e.data));
                    check($sformatf("sat %s", e.tag), 32'(scl_o_sat), 32'(e.sat));
                    check($sformatf("cycle %s", e.tag), cyc, e.cyc);
                    last_exp = e.data;
                end
            end else begin
                check("idle_sat", 32'(scl_o_sat), 32'd0);
                check("idle_hold", 32'(scl_o_data), 32'(last_exp));
            end
        end else begin
            last_exp = '0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_scl      = 1'b0;
        scl_cfg_mode   = 1'b0;
        scl_cfg_phase  = '0;
        scl_cfg_rnd    = 1'b0;
        scl_coef_we    = 1'b0;
        scl_coef_sel   = '0;
        scl_coef_wdata = '0;
        scl_i_data     = '0;
        scl_i_data_en  = 1'b0;

        repeat (3) @(posedge clk_scl);
        #1;
        check("reset_data", 32'(scl_o_data), 32'd0);
        check("reset_en", 32'(scl_o_data_en), 32'd0);
        check("reset_sat", 32'(scl_o_sat), 32'd0);
        @(negedge clk_scl);
        rst_n_scl = 1'b1;
        repeat (4) @(posedge clk_scl);

        // Bypass: distinct channels pass straight through.
        put(0, px(1, 50, 5), px(1, 50, 5), 1'b0);
        put(1, px(2, 60, 6), px(2, 60, 6), 1'b0);
        put(2, px(3, 70, 7), px(3, 70, 7), 1'b0);
        drive_line("bypass", 3, 1'b0, 2'd0, 1'b0, -1, 2'd0, 1'b0, 1);

        // Rounding, phase1, line 0,1,0. Truncation: last output is -38 -> clip.
        put(0, px3(0), px3(0), 1'b0);
        put(1, px3(1), px3(0), 1'b0);
        put(2, px3(0), px3(0), 1'b1);
        drive_line("rnd0", 3, 1'b1, 2'd1, 1'b0, -1, 2'd0, 1'b0, 1);
        put(0, px3(0), px3(0), 1'b0);
        put(1, px3(1), px3(1), 1'b0);
        put(2, px3(0), px3(0), 1'b0);
        drive_line("rnd1", 3, 1'b1, 2'd1, 1'b1, -1, 2'd0, 1'b0, 1);

        // Edge replication, phase3: 10,20,30 -> 19,29,30; channel 1 constant.
        put(0, px(10, 100, 10), px(19, 100, 19), 1'b0);
        put(1, px(20, 100, 20), px(29, 100, 29), 1'b0);
        put(2, px(30, 100, 30), px(30, 100, 30), 1'b0);
        drive_line("edges", 3, 1'b1, 2'd3, 1'b0, -1, 2'd0, 1'b0, 1);

        // Length-1 lines: coefficient sums are unity in every default phase.
        put(0, px3(77), px3(77), 1'b0);
        drive_line("len1_p0", 1, 1'b1, 2'd0, 1'b0, -1, 2'd0, 1'b0, 1);
        drive_line("len1_p2", 1, 1'b1, 2'd2, 1'b0, -1, 2'd0, 1'b0, 1);

        // Saturation high on channel 2 (140250 >> 9 = 273 -> 255).
        put(0, px(0, 100, 100),   px(86, 100, 100),  1'b0);
        put(1, px(255, 100, 100), px(255, 100, 100), 1'b1);
        put(2, px(255, 100, 100), px(255, 100, 100), 1'b0);
        put(3, px(255, 100, 100), px(255, 100, 100), 1'b0);
        drive_line("sat_hi", 4, 1'b1, 2'd1, 1'b0, -1, 2'd0, 1'b0, 1);

        // Saturation low on channel 0 (-9690 -> 0).
        put(0, px(100, 100, 255), px(100, 100, 168), 1'b0);
        put(1, px(100, 100, 0),   px(100, 100, 0),   1'b1);
        put(2, px(100, 100, 0),   px(100, 100, 0),   1'b0);
        put(3, px(100, 100, 0),   px(100, 100, 0),   1'b0);
        drive_line("sat_lo", 4, 1'b1, 2'd1, 1'b0, -1, 2'd0, 1'b0, 1);

        // Config latching: phase0 line; mid-line switch to phase1 and write
        // phase1 = identity. Current line stays phase0, next line is identity.
        put(0, px3(0),   px3(7),   1'b0);
        put(1, px3(200), px3(194), 1'b0);
        put(2, px3(0),   px3(5),   1'b0);
        put(3, px3(200), px3(201), 1'b0);
        drive_line("cfg_a", 4, 1'b1, 2'd0, 1'b0, 1, 2'd1, 1'b1, 1);
        put(0, px3(0),   px3(0),   1'b0);
        put(1, px3(200), px3(200), 1'b0);
        put(2, px3(0),   px3(0),   1'b0);
        put(3, px3(200), px3(200), 1'b0);
        drive_line("cfg_b", 4, 1'b1, 2'd1, 1'b0, -1, 2'd0, 1'b0, 1);
        put(0, px3(100), px3(100), 1'b0);
        put(1, px3(100), px3(100), 1'b0);
        put(2, px3(100), px3(100), 1'b0);
        drive_line("const100", 3, 1'b1, 2'd0, 1'b0, -1, 2'd0, 1'b0, 1);

        // Write-first: identity written to phase2 on the line-start cycle.
        put(0, px3(0),   px3(0),   1'b0);
        put(1, px3(200), px3(200), 1'b0);
        put(2, px3(0),   px3(0),   1'b0);
        put(3, px3(200), px3(200), 1'b0);
        drive_line("wfirst", 4, 1'b1, 2'd2, 1'b0, 0, 2'd2, 1'b0, 10);

        // Reset in the middle of an outputting line.
        for (int i = 0; i < 10; i++) begin
            exp_t e;
            @(posedge clk_scl);
            #1;
            scl_i_data    = px3(50);
            scl_i_data_en = 1'b1;
            scl_cfg_mode  = 1'b1;
            scl_cfg_phase = 2'd0;
            scl_cfg_rnd   = 1'b0;
            e.data = px3(50);
            e.sat  = 1'b0;
            e.cyc  = cyc + 7;
            e.tag  = "pre_rst";
            sb.push_back(e);
        end
        @(posedge clk_scl);
        #1;
        rst_n_scl = 1'b0;
        sb.delete();
        #1;
        check("midrst_data", 32'(scl_o_data), 32'd0);
        check("midrst_en", 32'(scl_o_data_en), 32'd0);
        check("midrst_sat", 32'(scl_o_sat), 32'd0);
        repeat (2) @(posedge clk_scl);
        @(negedge clk_scl);
        rst_n_scl = 1'b1;
        // The cut line keeps en high past release; none of it may appear.
        repeat (3) @(posedge clk_scl);
        #1;
        scl_i_data_en = 1'b0;
        scl_i_data    = '0;
        repeat (12) @(posedge clk_scl);

        // Defaults restored: phase2 original coefficients.
        put(0, px3(0),   px3(146), 1'b0);
        put(1, px3(200), px3(64),  1'b0);
        put(2, px3(0),   px3(121), 1'b0);
        put(3, px3(200), px3(210), 1'b0);
        drive_line("post_rst", 4, 1'b1, 2'd2, 1'b0, -1, 2'd0, 1'b0, 1);

        for (int w = 0; w < 50 && sb.size() != 0; w++) @(posedge clk_scl);
        repeat (3) @(posedge clk_scl);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
